// File: rtl/ddr3_port_responder.sv
// Behavioural stand-in for an MCB-style DDR3 user port.
// Command/write/read FIFOs plus an engine backed by block RAM.
module ddr3_port_responder #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int CAL_DELAY      = 16,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        calibration_done,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [27:0] cmd_word_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error
);

    localparam int AW        = MEM_ADDR_WIDTH;
    localparam int MEM_DEPTH = 1 << AW;
    localparam int CPW       = $clog2(CMD_FIFO_DEPTH);
    localparam int CEW       = 3 + 6 + AW;
    localparam int CAL_W     = $clog2(CAL_DELAY + 1);
    localparam int REF_W     = $clog2(REFRESH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        READ,
        READ_FLUSH,
        REFRESH
    } state_t;

    state_t state, state_n;

    logic [CAL_W-1:0] cal_cnt;

    logic [CEW-1:0] cmd_mem [CMD_FIFO_DEPTH];
    logic [CPW:0]   cmd_wp, cmd_rp;
    logic [CEW-1:0] cmd_head;
    logic           cmd_push, cmd_pop;

    logic [35:0]    wf_mem [64];
    logic [6:0]     wf_wp, wf_rp;
    logic [35:0]    wf_head;
    logic           wr_push, wr_pop, wr_err_set;

    logic [31:0]    rf_mem [64];
    logic [6:0]     rf_wp, rf_rp;
    logic           rd_push, rd_pop, rd_ovf_set, rd_err_set;

    logic [31:0]    mem [MEM_DEPTH];
    logic [31:0]    rd_word;
    logic           rd_word_vld;

    logic [2:0]       instr;
    logic [5:0]       beat;
    logic [AW-1:0]    addr;
    logic [REF_W-1:0] ref_cnt;
    logic             rd_issue, underrun_set;

    logic addr_unused;
    assign addr_unused = ^cmd_word_addr[27:AW];

    // Calibration counter: done after CAL_DELAY cycles out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_cnt          <= '0;
            calibration_done <= 1'b0;
        end else if (!calibration_done) begin
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == CAL_W'(CAL_DELAY - 1))
                calibration_done <= 1'b1;
        end
    end

    assign cmd_empty = (cmd_wp == cmd_rp);
    assign cmd_full  = (cmd_wp[CPW] != cmd_rp[CPW]) &&
                       (cmd_wp[CPW-1:0] == cmd_rp[CPW-1:0]);
    assign cmd_push  = calibration_done && cmd_en && !cmd_full;
    assign cmd_head  = cmd_mem[cmd_rp[CPW-1:0]];

    // Command FIFO; pushes while full are dropped silently
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wp <= '0;
            cmd_rp <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wp[CPW-1:0]] <=
                    {cmd_instr, cmd_bl, cmd_word_addr[AW-1:0]};
                cmd_wp <= cmd_wp + 1'b1;
            end
            if (cmd_pop)
                cmd_rp <= cmd_rp + 1'b1;
        end
    end

    assign wr_count   = wf_wp - wf_rp;
    assign wr_empty   = (wr_count == 7'd0);
    assign wr_full    = (wr_count == 7'd64);
    assign wf_head    = wf_mem[wf_rp[5:0]];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign wr_push    = calibration_done && wr_en && (!wr_full || wr_pop);
    assign wr_err_set = calibration_done && wr_en && wr_full && !wr_pop;

    // Write-data FIFO with sticky overrun error
    always_ff @(posedge clk) begin
        if (rst) begin
            wf_wp    <= '0;
            wf_rp    <= '0;
            wr_error <= 1'b0;
        end else begin
            if (wr_push) begin
                wf_mem[wf_wp[5:0]] <= {wr_mask, wr_data};
                wf_wp <= wf_wp + 1'b1;
            end
            if (wr_pop)
                wf_rp <= wf_rp + 1'b1;
            if (wr_err_set)
                wr_error <= 1'b1;
        end
    end

    assign rd_count   = rf_wp - rf_rp;
    assign rd_empty   = (rd_count == 7'd0);
    assign rd_full    = (rd_count == 7'd64);
    assign rd_data    = rd_empty ? 32'd0 : rf_mem[rf_rp[5:0]];
    assign rd_push    = rd_word_vld && !rd_full;
    assign rd_ovf_set = rd_word_vld && rd_full;
    assign rd_pop     = calibration_done && rd_en && !rd_empty;
    assign rd_err_set = calibration_done && rd_en && rd_empty;

    // Read-data FIFO, first-word fall-through, sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wp       <= '0;
            rf_rp       <= '0;
            rd_overflow <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            if (rd_push) begin
                rf_mem[rf_wp[5:0]] <= rd_word;
                rf_wp <= rf_wp + 1'b1;
            end
            if (rd_pop)
                rf_rp <= rf_rp + 1'b1;
            if (rd_ovf_set)
                rd_overflow <= 1'b1;
            if (rd_err_set)
                rd_error <= 1'b1;
        end
    end

    // Backing store: byte-masked writes, registered one-cycle reads
    always_ff @(posedge clk) begin
        if (wr_pop && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (!wf_head[32 + b])
                    mem[addr][8*b +: 8] <= wf_head[8*b +: 8];
            end
        end
        rd_word <= mem[addr];
    end

    // Engine state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Engine next-state and control strobes
    always_comb begin
        state_n      = state;
        cmd_pop      = 1'b0;
        wr_pop       = 1'b0;
        rd_issue     = 1'b0;
        underrun_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (!instr[2])
                    state_n = instr[0] ? READ : WRITE;
                else if (instr == 3'b100)
                    state_n = REFRESH;
                else
                    state_n = IDLE;
            end
            WRITE: begin
                if (wr_empty) begin
                    underrun_set = 1'b1;
                end else begin
                    wr_pop = 1'b1;
                    if (beat == 6'd0)
                        state_n = IDLE;
                end
            end
            READ: begin
                rd_issue = 1'b1;
                if (beat == 6'd0)
                    state_n = READ_FLUSH;
            end
            READ_FLUSH: state_n = IDLE;
            REFRESH: begin
                if (ref_cnt == '0)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Engine datapath: command latch, address/beat stepping, refresh timer
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            beat        <= '0;
            addr        <= '0;
            ref_cnt     <= '0;
            rd_word_vld <= 1'b0;
            wr_underrun <= 1'b0;
        end else begin
            rd_word_vld <= rd_issue;
            if (cmd_pop)
                {instr, beat, addr} <= cmd_head;
            if (wr_pop || rd_issue) begin
                addr <= addr + 1'b1;
                beat <= beat - 1'b1;
            end
            if (state == FETCH)
                ref_cnt <= REF_W'(REFRESH_CYCLES - 1);
            else if (state == REFRESH)
                ref_cnt <= ref_cnt - 1'b1;
            if (underrun_set)
                wr_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_port_responder.sv
// Directed bench for ddr3_port_responder: vector table for
// single-word write/read pairs plus hand-timed burst sequences.
module tb_ddr3_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        calibration_done;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [27:0] cmd_word_addr;
    logic        cmd_empty, cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full, wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun, wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full, rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow, rd_error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  wi;
        logic [27:0] wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [2:0]  ri;
        logic [27:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    ddr3_port_responder dut (
        .clk              (clk),
        .rst              (rst),
        .calibration_done (calibration_done),
        .cmd_en           (cmd_en),
        .cmd_instr        (cmd_instr),
        .cmd_bl           (cmd_bl),
        .cmd_word_addr    (cmd_word_addr),
        .cmd_empty        (cmd_empty),
        .cmd_full         (cmd_full),
        .wr_en            (wr_en),
        .wr_mask          (wr_mask),
        .wr_data          (wr_data),
        .wr_full          (wr_full),
        .wr_empty         (wr_empty),
        .wr_count         (wr_count),
        .wr_underrun      (wr_underrun),
        .wr_error         (wr_error),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .rd_full          (rd_full),
        .rd_empty         (rd_empty),
        .rd_count         (rd_count),
        .rd_overflow      (rd_overflow),
        .rd_error         (rd_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check(name,
              {calibration_done, cmd_empty, cmd_full, wr_full,
               wr_empty, wr_count, wr_underrun, wr_error, rd_full,
               rd_empty, rd_count, rd_overflow, rd_error},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 7'd0, 1'b0, 1'b0});
        check({name, "_rd_data"}, rd_data, 32'd0);
    endtask

    task automatic push_wr(input logic [3:0] m, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_mask = m;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_mask = '0;
        wr_data = '0;
    endtask

    task automatic send_cmd(input logic [2:0] i, input logic [5:0] bl,
                            input logic [27:0] a);
        cmd_en        = 1'b1;
        cmd_instr     = i;
        cmd_bl        = bl;
        cmd_word_addr = a;
        tick();
        cmd_en        = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        check(name, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_rd(input int n, input int budget,
                           input string name);
        for (int i = 0; i < budget && rd_count != 7'(n); i++)
            tick();
        check(name, 32'(rd_count), 32'(n));
    endtask

    task automatic wait_wr_empty(input int budget, input string name);
        for (int i = 0; i < budget && !wr_empty; i++)
            tick();
        check(name, 32'(wr_empty), 32'd1);
    endtask

    task automatic wait_cal(input string name);
        for (int i = 0; i < 40 && !calibration_done; i++)
            tick();
        check(name, 32'(calibration_done), 32'd1);
    endtask

    initial begin
        int wc_exp [4];

        vecs[0] = '{3'b000, 28'd5, 32'hFFFF_FFFF, 4'b0000,
                    3'b001, 28'd5, 32'hFFFF_FFFF};
        vecs[1] = '{3'b010, 28'd5, 32'h0000_0000, 4'b1010,
                    3'b011, 28'd5, 32'hFF00_FF00};
        vecs[2] = '{3'b000, 28'd5, 32'h1234_5678, 4'b0001,
                    3'b001, 28'd5, 32'h1234_5600};
        vecs[3] = '{3'b000, 28'd9, 32'hCAFE_BABE, 4'b0000,
                    3'b011, 28'd9, 32'hCAFE_BABE};
        vecs[4] = '{3'b010, 28'h409, 32'h0000_0000, 4'b1100,
                    3'b001, 28'd9, 32'hCAFE_0000};
        vecs[5] = '{3'b000, 28'h3FF, 32'hDEAD_BEEF, 4'b0000,
                    3'b001, 28'h7FF, 32'hDEAD_BEEF};
        vecs[6] = '{3'b000, 28'h3FF, 32'h0102_0304, 4'b1111,
                    3'b001, 28'h3FF, 32'hDEAD_BEEF};
        wc_exp = '{2, 2, 1, 0};

        rst           = 1'b1;
        cmd_en        = 1'b0;
        cmd_instr     = '0;
        cmd_bl        = '0;
        cmd_word_addr = '0;
        wr_en         = 1'b0;
        wr_mask       = '0;
        wr_data       = '0;
        rd_en         = 1'b0;

        repeat (3) tick();
        check_reset_state("reset");

        // calibration timing; strobes before it must be ignored
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cmd_en    = (k <= 14);
            cmd_instr = 3'b001;
            wr_en     = (k <= 14);
            rd_en     = (k <= 14);
            tick();
            check($sformatf("cal_done_k%0d", k),
                  32'(calibration_done), 32'(k >= 16));
        end
        cmd_en = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        check("precal_ignored",
              {29'd0, cmd_empty, wr_empty, rd_error},
              {29'd0, 1'b1, 1'b1, 1'b0});

        // single-word write/read pairs
        foreach (vecs[v]) begin
            push_wr(vecs[v].wm, vecs[v].wd);
            send_cmd(vecs[v].wi, 6'd0, vecs[v].wa);
            repeat (6) tick();
            send_cmd(vecs[v].ri, 6'd0, vecs[v].ra);
            wait_rd(1, 20, $sformatf("vec%0d_count", v));
            pop_check($sformatf("vec%0d_data", v), vecs[v].exp);
        end

        // write latency: pops at T+3 and T+4
        push_wr(4'b0000, 32'h3131_3131);
        push_wr(4'b0000, 32'h3232_3232);
        send_cmd(3'b000, 6'd1, 28'h40);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("wr_lat_k%0d", k),
                  32'(wr_count), 32'(wc_exp[k-1]));
        end

        // read latency: bl=0 read lands at T+4
        send_cmd(3'b001, 6'd0, 28'h41);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rd_lat_k%0d", k),
                  32'(rd_empty), 32'(k < 4));
        end
        pop_check("rd_lat_data", 32'h3232_3232);

        // 4-word burst write then read
        for (int i = 0; i < 4; i++)
            push_wr(4'b0000, 32'hA0 + 32'(i));
        send_cmd(3'b000, 6'd3, 28'h10);
        send_cmd(3'b001, 6'd3, 28'h10);
        wait_rd(4, 40, "burst_count");
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("burst_w%0d", i), 32'hA0 + 32'(i));
        check("burst_empty", 32'(rd_empty), 32'd1);

        // underrun: bl=7 with 3 words, then the remaining 5
        check("underrun_clear", 32'(wr_underrun), 32'd0);
        for (int i = 0; i < 3; i++)
            push_wr(4'b0000, 32'hB000_0000 + 32'(i));
        send_cmd(3'b000, 6'd7, 28'd0);
        repeat (10) tick();
        check("underrun_set",
              {24'd0, wr_underrun, wr_count},
              {24'd0, 1'b1, 7'd0});
        for (int i = 3; i < 8; i++)
            push_wr(4'b0000, 32'hB000_0000 + 32'(i));
        wait_wr_empty(40, "underrun_drain");
        repeat (3) tick();
        send_cmd(3'b001, 6'd7, 28'd0);
        wait_rd(8, 40, "underrun_count");
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("underrun_w%0d", i),
                      32'hB000_0000 + 32'(i));

        // undefined opcode is discarded
        send_cmd(3'b101, 6'd0, 28'd5);
        repeat (6) tick();
        check("undef_discard",
              {24'd0, cmd_empty, rd_count},
              {24'd0, 1'b1, 7'd0});

        // refresh holds the engine for 8 cycles
        send_cmd(3'b100, 6'd0, 28'd0);
        send_cmd(3'b001, 6'd0, 28'd5);
        for (int k = 2; k <= 14; k++) begin
            tick();
            check($sformatf("refresh_k%0d", k),
                  32'(rd_empty), 32'(k < 14));
        end
        pop_check("refresh_data", 32'hB000_0005);

        // fill write FIFO, overrun it, then flush to memory
        for (int i = 0; i < 64; i++)
            push_wr(4'b0000, 32'h1000 + 32'(i));
        check("wfifo_full",
              {23'd0, wr_full, wr_error, wr_count},
              {23'd0, 1'b1, 1'b0, 7'd64});
        push_wr(4'b0000, 32'hDEAD);
        check("wfifo_err",
              {23'd0, wr_full, wr_error, wr_count},
              {23'd0, 1'b1, 1'b1, 7'd64});
        send_cmd(3'b000, 6'd63, 28'd0);
        wait_wr_empty(200, "prefill_drain");
        repeat (3) tick();

        // two 64-word reads with no pops: second is dropped
        send_cmd(3'b001, 6'd63, 28'd0);
        send_cmd(3'b011, 6'd63, 28'd32);
        wait_rd(64, 300, "ovf_count");
        check("ovf_not_yet", 32'(rd_overflow), 32'd0);
        repeat (90) tick();
        check("ovf_state",
              {23'd0, rd_full, rd_overflow, rd_count},
              {23'd0, 1'b1, 1'b1, 7'd64});
        for (int i = 0; i < 64; i++)
            pop_check($sformatf("ovf_w%0d", i), 32'h1000 + 32'(i));
        check("ovf_drained",
              {30'd0, rd_empty, rd_full},
              {30'd0, 1'b1, 1'b0});

        // address wrap at the top of memory
        push_wr(4'b0000, 32'h11);
        push_wr(4'b0000, 32'h22);
        send_cmd(3'b000, 6'd1, 28'h3FF);
        wait_wr_empty(20, "wrap_drain");
        repeat (3) tick();
        send_cmd(3'b001, 6'd1, 28'h3FF);
        wait_rd(2, 30, "wrap_count");
        pop_check("wrap_top", 32'h11);
        pop_check("wrap_zero", 32'h22);
        send_cmd(3'b001, 6'd0, 28'd0);
        wait_rd(1, 20, "wrap0_count");
        pop_check("wrap0_data", 32'h22);

        // pop from empty read FIFO
        check("rd_err_clear", 32'(rd_error), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_err_set",
              {25'd0, rd_error, rd_count},
              {25'd0, 1'b1, 7'd0});

        // reset mid-burst: stalled write must not resume
        push_wr(4'b0000, 32'h77);
        send_cmd(3'b000, 6'd3, 28'h30);
        repeat (6) tick();
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'h99;
        repeat (2) tick();
        wr_en   = 1'b0;
        wr_data = '0;
        check_reset_state("reset2");
        rst = 1'b0;
        wait_cal("recal");
        push_wr(4'b0000, 32'h88);
        repeat (8) tick();
        check("no_resume", 32'(wr_count), 32'd1);
        send_cmd(3'b001, 6'd1, 28'h30);
        wait_rd(2, 30, "abort_count");
        pop_check("abort_w0", 32'h77);
        pop_check("abort_w1", 32'h1031);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
